// File: rtl/display_rx_pkg.sv
// display_rx_pkg
//   Shared types and constants for the display_rx receiver:
//   - rx_state_t    : receive FSM states (IDLE, SHIFT, STOP, DRAIN)
//   - FRAME_BITS_DEF: default serial frame length in bits
//   - SEG_TABLE     : active-low {g,f,e,d,c,b,a} patterns for BCD 0-9
//   - SEG_BLANK     : all segments off
package display_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      STOP,
      DRAIN
   } rx_state_t;

   localparam int unsigned FRAME_BITS_DEF = 16;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry i is the pattern for digit i.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

endpackage

// File: rtl/display_rx_seg7_decode.sv
// seg7_decode
//   Combinational BCD to 7-segment decoder.
//   Ports:
//     nibble : 4-bit BCD digit
//     seg_n  : segments {g,f,e,d,c,b,a}, active-low; 10-15 decode to blank
module seg7_decode
   import display_rx_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      if (nibble < 4'd10) begin
         seg_n = SEG_TABLE[nibble];
      end
   end

endmodule

// File: rtl/display_rx.sv
// display_rx
//   Receiving end of the serial display link. Deserializes a BCD frame sent
//   MSB first while ser_frame is high, checks its length, holds the last good
//   frame on bcd_out and scans it onto a multiplexed 7-segment display.
//   Ports:
//     clk         : link data clock, rising edge
//     rst         : synchronous reset, active-low
//     ser_data    : serial data bit, valid while ser_frame is high
//     ser_frame   : frame enable from the transmitter
//     bcd_out     : last accepted frame, digit 3 in the top nibble
//     frame_valid : one-cycle pulse coincident with a bcd_out update
//     frame_err   : one-cycle pulse on a rejected frame
//     seg         : segments {g,f,e,d,c,b,a}, active-low
//     an          : digit anodes, one-hot active-low
//   Build option:
//     DISPLAY_RX_BCD_CHECK_EN : reject frames containing a nibble above 9
module display_rx
   import display_rx_pkg::*;
#(
   parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 64
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ser_data,
   input  logic                  ser_frame,
   output logic [FRAME_BITS-1:0] bcd_out,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
   localparam int unsigned REF_W = $clog2(REFRESH_DIV);
   localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   rx_state_t             state;
   logic [FRAME_BITS-1:0] sreg;
   logic [CNT_W-1:0]      cnt;
   logic                  commit_pend;

   logic [REF_W-1:0]      ref_cnt;
   logic [DIG_W-1:0]      digit_idx;
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;

`ifdef DISPLAY_RX_BCD_CHECK_EN
   logic bcd_bad;

   always_comb begin
      bcd_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sreg[4*i +: 4] > 4'd9) begin
            bcd_bad = 1'b1;
         end
      end
   end
`endif

   // Receive FSM. Acceptance is decided in STOP and staged through
   // commit_pend so bcd_out/frame_valid land two edges after the last bit.
   // A frame starting right after STOP overwrites sreg on the same edge the
   // staged value is copied out, which is safe with non-blocking updates.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         sreg        <= '0;
         cnt         <= '0;
         commit_pend <= 1'b0;
         bcd_out     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         commit_pend <= 1'b0;

         if (commit_pend) begin
            bcd_out     <= sreg;
            frame_valid <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (ser_frame) begin
                  sreg  <= FRAME_BITS'(ser_data);
                  cnt   <= CNT_W'(1);
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               if (ser_frame) begin
                  sreg <= {sreg[FRAME_BITS-2:0], ser_data};
                  cnt  <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(FRAME_BITS - 1)) begin
                     state <= STOP;
                  end
               end else begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end
            end

            STOP: begin
               if (ser_frame) begin
                  frame_err <= 1'b1;
                  state     <= DRAIN;
               end else begin
`ifdef DISPLAY_RX_BCD_CHECK_EN
                  if (bcd_bad) begin
                     frame_err <= 1'b1;
                  end else begin
                     commit_pend <= 1'b1;
                  end
`else
                  commit_pend <= 1'b1;
`endif
                  state <= IDLE;
               end
            end

            DRAIN: begin
               if (!ser_frame) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Display scan. seg and an are registered together from the same digit
   // index, so exactly one anode is ever low.
   always_comb begin
      nibble = bcd_out[{digit_idx, 2'b00} +: 4];
   end

   seg7_decode u_seg7_decode (
      .nibble (nibble),
      .seg_n  (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         ref_cnt   <= '0;
         digit_idx <= '0;
         seg       <= SEG_BLANK;
         an        <= '1;
      end else begin
         seg <= seg_dec;
         an  <= ~(DIGITS'(1) << digit_idx);
         if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            if (digit_idx == DIG_W'(DIGITS - 1)) begin
               digit_idx <= '0;
            end else begin
               digit_idx <= digit_idx + DIG_W'(1);
            end
         end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_display_rx.sv
module tb_display_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        ser_data;
   logic        ser_frame;
   logic [15:0] bcd_out;
   logic        frame_valid;
   logic        frame_err;
   logic [6:0]  seg;
   logic [3:0]  an;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   display_rx #(
      .FRAME_BITS  (16),
      .DIGITS      (4),
      .REFRESH_DIV (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ser_data    (ser_data),
      .ser_frame   (ser_frame),
      .bcd_out     (bcd_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .seg         (seg),
      .an          (an)
   );

   typedef struct {
      logic [15:0] data;
      int          hi;
      logic [15:0] exp_bcd;
      int          exp_v;
      int          exp_e;
      int          exp_lat;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive ser_frame high for hi cycles (first 16 bits from d, MSB first),
   // then low for 8 cycles, counting pulses seen along the way.
   task automatic send(input logic [15:0] d, input int hi,
                       output int nv, output int ne, output int lat, output bit both);
      nv = 0; ne = 0; lat = -1; both = 0;
      for (int j = 0; j < hi + 8; j++) begin
         @(negedge clk);
         if (frame_valid) begin
            nv++;
            lat = (j - 1) - (hi - 1);
         end
         if (frame_err) ne++;
         if (frame_valid && frame_err) both = 1;
         if (j < hi) begin
            ser_frame = 1'b1;
            ser_data  = (j < 16) ? d[15 - j] : 1'b1;
         end else begin
            ser_frame = 1'b0;
            ser_data  = 1'b0;
         end
      end
   endtask

   task automatic run_frame(input string tag, input logic [15:0] d, input int hi,
                            input logic [15:0] exp_bcd, input int exp_v, input int exp_e,
                            input int exp_lat);
      int nv, ne, lat;
      bit both;
      send(d, hi, nv, ne, lat, both);
      check({tag, "_bcd"},   32'(bcd_out), 32'(exp_bcd));
      check({tag, "_valid"}, 32'(nv),      32'(exp_v));
      check({tag, "_err"},   32'(ne),      32'(exp_e));
      check({tag, "_lat"},   32'(lat),     32'(exp_lat));
      check({tag, "_excl"},  32'(both),    32'd0);
   endtask

   // Wait (bounded) until an shows the given pattern, then compare seg.
   task automatic seg_at(input string tag, input logic [3:0] anode, input logic [6:0] exp_seg);
      bit found = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (an == anode) begin
            found = 1;
            break;
         end
      end
      check({tag, "_found"}, 32'(found), 32'd1);
      check({tag, "_seg"},   32'(seg),   32'(exp_seg));
   endtask

   initial begin
      logic [6:0]  scan_seg [4];
      logic [3:0]  prev_an;
      logic [3:0]  exp_an;
      bit          found;
      int          pulses;

      vecs[0] = '{16'h1234, 16, 16'h1234, 1, 0, 2};
      vecs[1] = '{16'hFFFF, 10, 16'h1234, 0, 1, -1};
      vecs[2] = '{16'h5678, 20, 16'h1234, 0, 1, -1};
      vecs[3] = '{16'h0009, 16, 16'h0009, 1, 0, 2};
      vecs[4] = '{16'h1234, 16, 16'h1234, 1, 0, 2};

      scan_seg[0] = 7'h19;
      scan_seg[1] = 7'h30;
      scan_seg[2] = 7'h24;
      scan_seg[3] = 7'h79;

      rst = 1'b0; ser_frame = 1'b0; ser_data = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bcd",   32'(bcd_out),     32'h0);
      check("rst_valid", 32'(frame_valid), 32'h0);
      check("rst_err",   32'(frame_err),   32'h0);
      check("rst_seg",   32'(seg),         32'h7F);
      check("rst_an",    32'(an),          32'hF);
      rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].hi,
                   vecs[i].exp_bcd, vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_lat);
      end

      // Scan sequence on bcd_out = 1234 with a 4-cycle dwell.
      prev_an = an;
      found = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (an == 4'b1110 && prev_an != 4'b1110) begin
            found = 1;
            break;
         end
         prev_an = an;
      end
      check("scan_sync", 32'(found), 32'd1);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         exp_an = ~(4'b0001 << (c / 4));
         check($sformatf("scan_an%0d", c),  32'(an),  32'(exp_an));
         check($sformatf("scan_seg%0d", c), 32'(seg), 32'(scan_seg[c / 4]));
      end

      // Non-BCD nibble in an otherwise good frame.
`ifdef DISPLAY_RX_BCD_CHECK_EN
      run_frame("nonbcd", 16'h12A4, 16, 16'h1234, 0, 1, -1);
      seg_at("nonbcd_d1", 4'b1101, 7'h30);
`else
      run_frame("nonbcd", 16'h12A4, 16, 16'h12A4, 1, 0, 2);
      seg_at("nonbcd_d1", 4'b1101, 7'h7F);
`endif
      seg_at("nonbcd_d0", 4'b1110, 7'h19);

      // Reset in the middle of a frame.
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         ser_frame = 1'b1;
         ser_data  = j[0];
      end
      @(negedge clk);
      rst = 1'b0; ser_frame = 1'b0; ser_data = 1'b0;
      @(negedge clk);
      check("mrst_bcd",   32'(bcd_out),     32'h0);
      check("mrst_valid", 32'(frame_valid), 32'h0);
      check("mrst_err",   32'(frame_err),   32'h0);
      check("mrst_seg",   32'(seg),         32'h7F);
      check("mrst_an",    32'(an),          32'hF);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (frame_valid || frame_err) pulses++;
      end
      check("mrst_nopulse", 32'(pulses), 32'd0);

      run_frame("after_rst", 16'h9999, 16, 16'h9999, 1, 0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
